abc_pattern_driver: RTL and testbench

- Synthesizable stimulus source for the a/b/c handshake rule: if c is high on a clock cycle, a and b are equal on the next cycle.
- Produces pseudo-random a, b and c from an LFSR for a programmed number of cycles and always honours the rule.
- Has a one-shot error injection that deliberately breaks the rule once, so downstream concurrent assertions can be shown to fire.
- Sits in front of the assertion-bearing modules as their driver.

---
 rtl/abc_pattern_driver.sv | 128 ++++++++++++
 tb/tb_abc_pattern_driver.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/abc_pattern_driver.sv
// abc_pattern_driver: LFSR-driven a/b/c stimulus source. Whenever c is high on a
// cycle, a and b are equal on the following cycle. A one-shot error injection
// breaks that rule exactly once per request so downstream assertions can be
// exercised.
module abc_pattern_driver #(
  parameter int                 LFSR_W   = 16,
  parameter logic [LFSR_W-1:0]  SEED     = 16'hACE1,
  parameter int                 CNT_W    = 16,
  parameter int                 C_THRESH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_cycles,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              inject_err,
  output logic              busy,
  output logic              done,
  output logic              a,
  output logic              b,
  output logic              c,
  output logic [CNT_W-1:0]  c_count,
  output logic [CNT_W-1:0]  err_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Galois tap mask for x^16+x^14+x^13+x^11+1, right-shifting form
  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(16'hB400);
  // 5-bit threshold so that C_THRESH=16 (c always) is representable
  localparam logic [4:0]        THR  = 5'(C_THRESH);

  state_t             state, state_nx;
  logic [LFSR_W-1:0]  lfsr, lfsr_nx, lfsr_step;
  logic [CNT_W-1:0]   remaining, remaining_nx;
  logic [CNT_W-1:0]   c_count_nx, err_count_nx;
  logic               pending_err, pending_nx;
  logic               a_nx, b_nx, c_nx, busy_nx, done_nx;
  logic               c_new, err_now;

  assign lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
  // Last run cycle never raises c, so no obligation spills past the run
  assign c_new     = ({1'b0, lfsr[3:0]} < THR) && (remaining != CNT_W'(1));
  // A request arriving on the obligation cycle itself is consumed immediately
  assign err_now   = pending_err | inject_err;

  // Next-state and next-output decode; everything defaults to hold / zero
  always_comb begin
    state_nx     = state;
    lfsr_nx      = lfsr;
    remaining_nx = remaining;
    pending_nx   = pending_err;
    c_count_nx   = c_count;
    err_count_nx = err_count;
    a_nx         = 1'b0;
    b_nx         = 1'b0;
    c_nx         = 1'b0;
    busy_nx      = 1'b0;
    done_nx      = 1'b0;
    case (state)
      IDLE: begin
        if (seed_load) lfsr_nx = (seed == '0) ? SEED : seed;
        if (start) begin
          remaining_nx = num_cycles;
          c_count_nx   = '0;
          err_count_nx = '0;
          pending_nx   = 1'b0;
          state_nx     = (num_cycles == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        lfsr_nx = lfsr_step;
        busy_nx = 1'b1;
        c_nx    = c_new;
        a_nx    = lfsr[4];
        if (c) begin
          // obligation cycle: a==b unless a violation is pending
          b_nx       = err_now ? ~lfsr[4] : lfsr[4];
          pending_nx = 1'b0;
          if (err_now && err_count != '1) err_count_nx = err_count + CNT_W'(1);
        end else begin
          b_nx       = lfsr[5];
          pending_nx = err_now;
        end
        if (c_new && c_count != '1) c_count_nx = c_count + CNT_W'(1);
        remaining_nx = remaining - CNT_W'(1);
        if (remaining == CNT_W'(1)) state_nx = DONE;
      end
      DONE: begin
        done_nx    = 1'b1;
        pending_nx = 1'b0;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and registered outputs; synchronous reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lfsr        <= SEED;
      remaining   <= '0;
      pending_err <= 1'b0;
      c_count     <= '0;
      err_count   <= '0;
      a           <= 1'b0;
      b           <= 1'b0;
      c           <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nx;
      lfsr        <= lfsr_nx;
      remaining   <= remaining_nx;
      pending_err <= pending_nx;
      c_count     <= c_count_nx;
      err_count   <= err_count_nx;
      a           <= a_nx;
      b           <= b_nx;
      c           <= c_nx;
      busy        <= busy_nx;
      done        <= done_nx;
    end
  end

endmodule

// File: tb/tb_abc_pattern_driver.sv
// Scoreboard bench for abc_pattern_driver: three instances (C_THRESH 0, 4, 16)
// share stimulus; a run-level reference model pushes expected per-cycle outputs
// and an independent negedge monitor pops/compares whenever a DUT shows busy/done.
module tb_abc_pattern_driver;

  localparam logic [15:0] SEED = 16'hACE1;

  typedef struct packed {
    logic a, b, c, busy, done;
    logic [15:0] cc, ec;
  } obs_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, seed_load = 1'b0, inject_err = 1'b0;
  logic [15:0] num_cycles = '0, seed = '0;
  logic busy[3], done[3], a[3], b[3], c[3];
  logic [15:0] cc[3], ec[3];

  obs_t exp_q[3][$];
  int   total = 0, bad = 0;
  int   viol[3] = '{0, 0, 0};
  logic prev_c[3] = '{1'b0, 1'b0, 1'b0};
  int   exp_err[3];
  logic [15:0] exp_cc[3], exp_ec[3];
  logic [15:0] mlfsr = SEED;
  int   TH[3] = '{0, 4, 16};
  bit   inj[0:63];

  always #5 clk = ~clk;

  abc_pattern_driver #(.C_THRESH(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .num_cycles(num_cycles), .seed_load(seed_load),
    .seed(seed), .inject_err(inject_err), .busy(busy[0]), .done(done[0]), .a(a[0]),
    .b(b[0]), .c(c[0]), .c_count(cc[0]), .err_count(ec[0]));
  abc_pattern_driver #(.C_THRESH(4)) u1 (
    .clk(clk), .rst(rst), .start(start), .num_cycles(num_cycles), .seed_load(seed_load),
    .seed(seed), .inject_err(inject_err), .busy(busy[1]), .done(done[1]), .a(a[1]),
    .b(b[1]), .c(c[1]), .c_count(cc[1]), .err_count(ec[1]));
  abc_pattern_driver #(.C_THRESH(16)) u2 (
    .clk(clk), .rst(rst), .start(start), .num_cycles(num_cycles), .seed_load(seed_load),
    .seed(seed), .inject_err(inject_err), .busy(busy[2]), .done(done[2]), .a(a[2]),
    .b(b[2]), .c(c[2]), .c_count(cc[2]), .err_count(ec[2]));

  function automatic obs_t obs(int i);
    obs_t o;
    o = {a[i], b[i], c[i], busy[i], done[i], cc[i], ec[i]};
    return o;
  endfunction

  function automatic logic [15:0] lstep(logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  // Monitor: rule-violation tracking and scoreboard pops
  always @(negedge clk) begin
    obs_t e;
    for (int i = 0; i < 3; i++) begin
      if (prev_c[i] && (a[i] !== b[i])) viol[i]++;
      prev_c[i] = c[i];
      if (busy[i] || done[i]) begin
        total++;
        if (exp_q[i].size() == 0) begin
          bad++;
          $display("FAIL dut%0d unexpected_output got=%h expected=none", i, obs(i));
        end else begin
          e = exp_q[i].pop_front();
          if (obs(i) !== e) begin
            bad++;
            $display("FAIL dut%0d cycle_output got=%h expected=%h", i, obs(i), e);
          end
        end
      end
    end
  end

  // Reference model: whole run computed from the pattern rules
  task automatic model_run(input int n, input int keep);
    logic [15:0] l, mcc, mec;
    bit pc, pend, nc, ea, eb, eff;
    obs_t o;
    for (int i = 0; i < 3; i++) begin
      l = mlfsr; pc = 0; pend = 0; mcc = 0; mec = 0;
      for (int k = 1; k <= n && k <= keep; k++) begin
        eff = pend | inj[k];
        nc  = (k != n) && (int'(l[3:0]) < TH[i]);
        ea  = l[4];
        if (pc) begin
          eb = eff ? ~l[4] : l[4];
          if (eff) mec++;
          pend = 0;
        end else begin
          eb = l[5];
          pend = eff;
        end
        if (nc) mcc++;
        o = {ea, eb, nc, 1'b1, 1'b0, mcc, mec};
        exp_q[i].push_back(o);
        l = lstep(l);
        pc = nc;
      end
      if (keep >= n) begin
        o = {3'b000, 1'b0, 1'b1, mcc, mec};
        exp_q[i].push_back(o);
      end
      exp_err[i] = int'(mec);
      exp_cc[i] = mcc;
      exp_ec[i] = mec;
    end
    mlfsr = l;
  endtask

  task automatic junk();
    start      = 1'($urandom % 2);
    seed_load  = 1'($urandom % 2);
    seed       = 16'($urandom);
    num_cycles = 16'($urandom_range(0, 5));
  endtask

  task automatic clear_in();
    start = 0; seed_load = 0; inject_err = 0; num_cycles = '0; seed = '0;
  endtask

  task automatic check_state(input string tag, input bit held);
    obs_t e;
    for (int i = 0; i < 3; i++) begin
      e = held ? {5'b0, exp_cc[i], exp_ec[i]} : '0;
      total++;
      if (obs(i) !== e) begin
        bad++;
        $display("FAIL dut%0d %s got=%h expected=%h", i, tag, obs(i), e);
      end
    end
  endtask

  task automatic check_drained(input string tag);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (exp_q[i].size() != 0) begin
        bad++;
        $display("FAIL dut%0d %s_pending got=%0d expected=0", i, tag, exp_q[i].size());
        exp_q[i].delete();
      end
    end
  endtask

  // mode: 0 none, 1 single at edge k1, 2 held high, 3 random; keep<n aborts by reset
  task automatic do_run(input int n, input bit sl, input logic [15:0] sd,
                        input int mode, input int k1, input int keep);
    for (int k = 0; k < 64; k++)
      inj[k] = (mode == 1) ? (k == k1) : (mode == 2) ? 1'b1 :
               (mode == 3) ? ($urandom % 6 == 0) : 1'b0;
    if (sl) mlfsr = (sd == 16'h0) ? SEED : sd;
    model_run(n, keep);
    for (int i = 0; i < 3; i++) viol[i] = 0;
    start = 1; num_cycles = 16'(n); seed_load = sl; seed = sd;
    @(posedge clk); #1;
    junk();
    inject_err = inj[1];
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      if (k == keep && keep < n) begin
        clear_in();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        mlfsr = SEED;
        check_drained("abort");
        check_state("after_abort", 1'b0);
        repeat (3) @(posedge clk);
        #1;
        return;
      end
      junk();
      inject_err = (k < n) ? inj[k + 1] : 1'($urandom % 2);
    end
    @(posedge clk); #1;
    clear_in();
    @(posedge clk); #1;
    check_drained("run");
    check_state("hold_after_done", 1'b1);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (viol[i] != exp_err[i]) begin
        bad++;
        $display("FAIL dut%0d rule_violations got=%0d expected=%0d", i, viol[i], exp_err[i]);
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    repeat (5) @(posedge clk);
    #1;
    check_state("reset_idle", 1'b0);

    do_run(10, 0, 16'h0, 0, 0, 99);
    do_run(8, 0, 16'h0, 1, 4, 99);
    do_run(20, 0, 16'h0, 2, 0, 99);
    do_run(0, 0, 16'h0, 2, 0, 99);

    // zero seed falls back to SEED; two identical runs
    for (int r = 0; r < 2; r++) begin
      seed_load = 1; seed = 16'h0;
      @(posedge clk); #1;
      seed_load = 0;
      mlfsr = SEED;
      do_run(12, 0, 16'h0, 0, 0, 99);
    end
    do_run(9, 1, 16'h0, 3, 0, 99);
    do_run(9, 1, 16'h1234, 3, 0, 99);

    for (int r = 0; r < 20; r++) begin
      repeat ($urandom_range(0, 3)) begin
        inject_err = 1'($urandom % 2);
        @(posedge clk); #1;
      end
      inject_err = 0;
      do_run($urandom_range(0, 40), 1'($urandom % 2),
             ($urandom % 4 == 0) ? 16'h0 : 16'($urandom),
             $urandom_range(0, 3), $urandom_range(1, 40), 99);
    end

    do_run(10, 0, 16'h0, 0, 0, 4);
    do_run(6, 0, 16'h0, 0, 0, 99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
